// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module : audio_pkg
// Brief  : Shared constants and FSM encoding for the serial audio receiver.
// Rev    : 1.0  initial release
// ============================================================================
package audio_pkg;

    localparam int AUDIO_W        = 16;
    localparam int BITS_PER_FRAME = 2 * AUDIO_W;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        RIGHT = 2'd1,
        LEFT  = 2'd2
    } audio_state_e;

    function automatic logic state_is_locked(audio_state_e s);
        return (s == RIGHT) || (s == LEFT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_rx_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module : audio_rx_deserializer_if
// Brief  : Serial audio inputs and parallel stereo-word outputs of the receiver.
// Rev    : 1.0  initial release
// ============================================================================
interface audio_rx_deserializer_if #(
    parameter int DATA_W = audio_pkg::AUDIO_W
);
    logic              audio_bck;
    logic              audio_ws;
    logic              audio_data;
    logic [DATA_W-1:0] audio_out_left;
    logic [DATA_W-1:0] audio_out_right;
    logic              sample_valid;
    logic              frame_err;
    logic              locked;

    // master is the serial source / sample consumer side, slave is the receiver
    modport master (
        output audio_bck, audio_ws, audio_data,
        input  audio_out_left, audio_out_right, sample_valid, frame_err, locked
    );

    modport slave (
        input  audio_bck, audio_ws, audio_data,
        output audio_out_left, audio_out_right, sample_valid, frame_err, locked
    );
endinterface
`default_nettype wire

// File: rtl/audio_sync.sv
`default_nettype none
// ============================================================================
// Module : audio_sync
// Brief  : Multi-flop synchronizer for one asynchronous single-bit input.
// Rev    : 1.0  initial release
// ============================================================================
module audio_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    // Fewer than two flops cannot resolve metastability; clamp silently.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/audio_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module : audio_rx_deserializer
// Brief  : Recovers right/left PCM word pairs from an external bck/ws/data link.
// Rev    : 1.0  initial release
// ============================================================================
module audio_rx_deserializer
    import audio_pkg::*;
#(
    parameter int DATA_W      = AUDIO_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    audio_rx_deserializer_if.slave  bus
);
    localparam int              CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

    logic bck_sync;
    logic ws_sync;
    logic data_sync;

    audio_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bck (
        .clk (clk), .rst_n (rst_n), .d (bus.audio_bck),  .q (bck_sync)
    );
    audio_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ws (
        .clk (clk), .rst_n (rst_n), .d (bus.audio_ws),   .q (ws_sync)
    );
    audio_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
        .clk (clk), .rst_n (rst_n), .d (bus.audio_data), .q (data_sync)
    );

    // Edge-detect stage: ws/data are captured alongside the rise flag so they
    // come from the same synchronizer sample as the detected bck edge.
    logic bck_prev_q, bck_prev_d;
    logic rise_q,     rise_d;
    logic ws_q,       ws_d;
    logic data_q,     data_d;

    always_comb begin
        bck_prev_d = bck_sync;
        rise_d     = bck_sync & ~bck_prev_q;
        ws_d       = ws_sync;
        data_d     = data_sync;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bck_prev_q <= 1'b0;
            rise_q     <= 1'b0;
            ws_q       <= 1'b0;
            data_q     <= 1'b0;
        end else begin
            bck_prev_q <= bck_prev_d;
            rise_q     <= rise_d;
            ws_q       <= ws_d;
            data_q     <= data_d;
        end
    end

    audio_state_e      state_q,      state_d;
    logic              ws_prev_q,    ws_prev_d;
    logic [DATA_W-1:0] shift_q,      shift_d;
    logic [CNT_W-1:0]  bit_cnt_q,    bit_cnt_d;
    logic [DATA_W-1:0] right_hold_q, right_hold_d;
    logic              pair_q,       pair_d;
    logic              err_q,        err_d;
    logic [DATA_W-1:0] out_left_q,   out_left_d;
    logic [DATA_W-1:0] out_right_q,  out_right_d;
    logic              valid_q,      valid_d;
    logic              ferr_q,       ferr_d;
    logic              locked_q,     locked_d;

    logic [DATA_W-1:0] shift_in;
    logic [DATA_W-1:0] shift_fresh;
    logic              word_full;

    always_comb begin
        state_d      = state_q;
        ws_prev_d    = ws_prev_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        right_hold_d = right_hold_q;
        pair_d       = 1'b0;
        err_d        = 1'b0;
        shift_in     = {shift_q[DATA_W-2:0], data_q};
        shift_fresh  = {{(DATA_W-1){1'b0}}, data_q};
        word_full    = (bit_cnt_q == CNT_FULL);

        if (rise_q) begin
            ws_prev_d = ws_q;
            unique case (state_q)
                HUNT: begin
                    if (ws_prev_q && !ws_q) begin
                        state_d   = RIGHT;
                        shift_d   = shift_fresh;
                        bit_cnt_d = CNT_ONE;
                    end
                end
                RIGHT, LEFT: begin
                    if (ws_q == ws_prev_q) begin
                        if (word_full) begin
                            // Overlong word: framing is lost, resynchronise.
                            err_d     = 1'b1;
                            state_d   = HUNT;
                            shift_d   = '0;
                            bit_cnt_d = '0;
                        end else begin
                            shift_d   = shift_in;
                            bit_cnt_d = bit_cnt_q + CNT_ONE;
                            if (bit_cnt_q == CNT_FULL - CNT_ONE) begin
                                if (state_q == RIGHT) begin
                                    right_hold_d = shift_in;
                                end else begin
                                    pair_d = 1'b1;
                                end
                            end
                        end
                    end else if (word_full) begin
                        state_d   = ws_q ? LEFT : RIGHT;
                        shift_d   = shift_fresh;
                        bit_cnt_d = CNT_ONE;
                    end else begin
                        // Short word: only a falling ws edge marks a trustworthy
                        // right-word start; a rising edge means we must re-hunt.
                        err_d = 1'b1;
                        if (!ws_q) begin
                            state_d   = RIGHT;
                            shift_d   = shift_fresh;
                            bit_cnt_d = CNT_ONE;
                        end else begin
                            state_d   = HUNT;
                            shift_d   = '0;
                            bit_cnt_d = '0;
                        end
                    end
                end
                default: begin
                    state_d   = HUNT;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                end
            endcase
        end

        // shift_q and right_hold_q are stable here: bck edges are >= 4 clk apart.
        out_left_d  = pair_q ? shift_q      : out_left_q;
        out_right_d = pair_q ? right_hold_q : out_right_q;
        valid_d     = pair_q;
        ferr_d      = err_q;
        locked_d    = state_is_locked(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            ws_prev_q    <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            right_hold_q <= '0;
            pair_q       <= 1'b0;
            err_q        <= 1'b0;
            out_left_q   <= '0;
            out_right_q  <= '0;
            valid_q      <= 1'b0;
            ferr_q       <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ws_prev_q    <= ws_prev_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            right_hold_q <= right_hold_d;
            pair_q       <= pair_d;
            err_q        <= err_d;
            out_left_q   <= out_left_d;
            out_right_q  <= out_right_d;
            valid_q      <= valid_d;
            ferr_q       <= ferr_d;
            locked_q     <= locked_d;
        end
    end

    assign bus.audio_out_left  = out_left_q;
    assign bus.audio_out_right = out_right_q;
    assign bus.sample_valid    = valid_q;
    assign bus.frame_err       = ferr_q;
    assign bus.locked          = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module : tb_audio_rx_deserializer
// Brief  : Self-checking bench: serial transmitter model plus pair scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
module tb_audio_rx_deserializer;

    localparam int DATA_W      = 16;
    localparam int SYNC_STAGES = 2;
    // clk posedges from the bck-high drive point to output visibility
    localparam int LAT         = SYNC_STAGES + 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    audio_rx_deserializer_if #(.DATA_W(DATA_W)) bus ();

    audio_rx_deserializer #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp       = 0;
    int   n_fail      = 0;
    int   cyc         = 0;
    int   valid_cnt   = 0;
    int   err_cnt     = 0;
    int   err_cyc     = -1;
    int   exp_err_cyc = -2;

    always @(posedge clk) cyc++;

    // Monitor: pops the scoreboard on every valid pulse
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (bus.sample_valid) begin
                valid_cnt++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_valid: got left=%h right=%h, required no pulse",
                             bus.audio_out_left, bus.audio_out_right);
                end else begin
                    e = sb.pop_front();
                    if (bus.audio_out_left !== e.l) begin
                        n_fail++;
                        $display("FAIL pair_left: got %h, required %h", bus.audio_out_left, e.l);
                    end
                    n_cmp++;
                    if (bus.audio_out_right !== e.r) begin
                        n_fail++;
                        $display("FAIL pair_right: got %h, required %h", bus.audio_out_right, e.r);
                    end
                    n_cmp++;
                    if (cyc !== e.cyc) begin
                        n_fail++;
                        $display("FAIL valid_latency: got cycle %0d, required %0d", cyc, e.cyc);
                    end
                end
            end
            if (bus.frame_err) begin
                err_cnt++;
                err_cyc = cyc;
                n_cmp++;
                if (bus.sample_valid) begin
                    n_fail++;
                    $display("FAIL err_and_valid: got both high, required exclusive");
                end
            end
        end
    end

    task automatic send_bit(input logic ws, input logic d, input logic push,
                            input logic [15:0] el, input logic [15:0] er,
                            input logic mark_err);
        exp_t e;
        @(negedge clk);
        bus.audio_bck  = 1'b0;
        bus.audio_ws   = ws;
        bus.audio_data = d;
        repeat (3) @(negedge clk);
        @(negedge clk);
        bus.audio_bck = 1'b1;
        if (push) begin
            e.l   = el;
            e.r   = er;
            e.cyc = cyc + LAT;
            sb.push_back(e);
        end
        if (mark_err) exp_err_cyc = cyc + LAT;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_word(input logic ws, input logic [15:0] w, input int nbits,
                             input logic push, input logic [15:0] el,
                             input logic [15:0] er, input int err_idx);
        for (int i = 0; i < nbits; i++) begin
            logic b;
            b = (i < 16) ? w[15-i] : 1'b0;
            send_bit(ws, b, push && (i == 15), el, er, i == err_idx);
        end
    endtask

    task automatic send_frame(input logic [15:0] r, input logic [15:0] l);
        send_word(1'b0, r, 16, 1'b0, 16'h0, 16'h0, -1);
        send_word(1'b1, l, 16, 1'b1, l, r, -1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_outputs(input string name, input logic [15:0] l,
                                 input logic [15:0] r);
        n_cmp++;
        if (bus.audio_out_left !== l) begin
            n_fail++;
            $display("FAIL %s_left: got %h, required %h", name, bus.audio_out_left, l);
        end
        n_cmp++;
        if (bus.audio_out_right !== r) begin
            n_fail++;
            $display("FAIL %s_right: got %h, required %h", name, bus.audio_out_right, r);
        end
    endtask

    task automatic check_int(input string name, input int got, input int req);
        n_cmp++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset", 16'h0, 16'h0);
        check_int("reset_valid",  int'(bus.sample_valid), 0);
        check_int("reset_err",    int'(bus.frame_err),    0);
        check_int("reset_locked", int'(bus.locked),       0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_int("post_reset_locked", int'(bus.locked), 0);
    endtask

    task automatic test_clean();
        int v0 = valid_cnt;
        int e0 = err_cnt;
        send_word(1'b1, 16'h0, 16, 1'b0, 16'h0, 16'h0, -1);
        check_int("clean_not_locked_yet", int'(bus.locked), 0);
        send_bit(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (4) @(negedge clk);
        check_int("clean_locked", int'(bus.locked), 1);
        send_word(1'b0, 16'hA5C3 << 1, 15, 1'b0, 16'h0, 16'h0, -1);
        send_word(1'b1, 16'h1234, 16, 1'b1, 16'h1234, 16'hA5C3, -1);
        send_frame(16'hA5C3, 16'h1234);
        send_frame(16'hA5C3, 16'h1234);
        repeat (8) @(negedge clk);
        check_int("clean_valid_count", valid_cnt - v0, 3);
        check_int("clean_err_count",   err_cnt - e0,   0);
        check_outputs("clean", 16'h1234, 16'hA5C3);
    endtask

    task automatic test_extremes();
        int v0 = valid_cnt;
        send_frame(16'h8000, 16'h0001);
        repeat (8) @(negedge clk);
        check_outputs("extreme1", 16'h0001, 16'h8000);
        send_frame(16'hFFFF, 16'h0000);
        repeat (8) @(negedge clk);
        check_outputs("extreme2", 16'h0000, 16'hFFFF);
        check_int("extreme_valid_count", valid_cnt - v0, 2);
    endtask

    task automatic test_short_word();
        int v0 = valid_cnt;
        int e0 = err_cnt;
        send_word(1'b0, 16'h5A5A, 12, 1'b0, 16'h0, 16'h0, -1);
        send_word(1'b1, 16'h7777, 16, 1'b0, 16'h0, 16'h0, 0);
        repeat (8) @(negedge clk);
        check_int("short_err_count", err_cnt - e0, 1);
        check_int("short_err_cycle", err_cyc, exp_err_cyc);
        check_int("short_no_valid",  valid_cnt - v0, 0);
        check_outputs("short_hold", 16'h0000, 16'hFFFF);
        send_frame(16'h0F0F, 16'hF0F0);
        repeat (8) @(negedge clk);
        check_int("short_recover", valid_cnt - v0, 1);
    endtask

    task automatic test_long_word();
        int v0 = valid_cnt;
        int e0 = err_cnt;
        send_word(1'b0, 16'hC0DE, 20, 1'b0, 16'h0, 16'h0, 16);
        check_int("long_unlocked", int'(bus.locked), 0);
        send_word(1'b1, 16'h3C3C, 16, 1'b0, 16'h0, 16'h0, -1);
        check_int("long_err_count", err_cnt - e0, 1);
        check_int("long_err_cycle", err_cyc, exp_err_cyc);
        check_int("long_still_unlocked", int'(bus.locked), 0);
        check_int("long_no_valid", valid_cnt - v0, 0);
        send_frame(16'h6789, 16'hABCD);
        repeat (8) @(negedge clk);
        check_int("long_relocked", int'(bus.locked), 1);
        check_int("long_recover", valid_cnt - v0, 1);
        check_outputs("long", 16'hABCD, 16'h6789);
    endtask

    task automatic test_mid_frame_start();
        int v0;
        pulse_reset();
        v0 = valid_cnt;
        send_word(1'b1, 16'hBEEF, 8, 1'b0, 16'h0, 16'h0, -1);
        send_frame(16'h1357, 16'h2468);
        repeat (8) @(negedge clk);
        check_int("mid_left_valid", valid_cnt - v0, 1);
        check_outputs("mid_left", 16'h2468, 16'h1357);
        pulse_reset();
        v0 = valid_cnt;
        send_word(1'b0, 16'hDEAD, 8, 1'b0, 16'h0, 16'h0, -1);
        send_word(1'b1, 16'h9999, 16, 1'b0, 16'h0, 16'h0, -1);
        check_int("mid_right_no_valid", valid_cnt - v0, 0);
        send_frame(16'h4321, 16'h8765);
        repeat (8) @(negedge clk);
        check_int("mid_right_valid", valid_cnt - v0, 1);
    endtask

    task automatic test_reset_mid_frame();
        int          v0;
        logic [15:0] w = 16'h2A2A;
        send_frame(16'h1111, 16'h2222);
        send_word(1'b0, 16'h3333, 16, 1'b0, 16'h0, 16'h0, -1);
        v0 = valid_cnt;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) begin
                @(negedge clk);
                bus.audio_bck  = 1'b0;
                bus.audio_ws   = 1'b1;
                bus.audio_data = w[7];
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                check_outputs("rst_mid", 16'h0, 16'h0);
                check_int("rst_mid_locked", int'(bus.locked), 0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                bus.audio_bck = 1'b1;
                repeat (3) @(negedge clk);
            end else begin
                send_bit(1'b1, w[15-i], 1'b0, 16'h0, 16'h0, 1'b0);
            end
        end
        check_int("rst_mid_no_valid", valid_cnt - v0, 0);
        check_outputs("rst_mid_held", 16'h0, 16'h0);
        send_frame(16'h4444, 16'h5555);
        repeat (8) @(negedge clk);
        check_int("rst_mid_relock_valid", valid_cnt - v0, 1);
        check_outputs("rst_mid_relock", 16'h5555, 16'h4444);
    endtask

    task automatic test_back_to_back();
        int          v0 = valid_cnt;
        logic [15:0] r;
        logic [15:0] l;
        for (int k = 0; k < 4; k++) begin
            r = 16'($urandom);
            l = 16'($urandom);
            send_frame(r, l);
        end
        repeat (8) @(negedge clk);
        check_int("b2b_valid_count", valid_cnt - v0, 4);
    endtask

    initial begin
        bus.audio_bck  = 1'b0;
        bus.audio_ws   = 1'b0;
        bus.audio_data = 1'b0;
        test_reset();
        test_clean();
        test_extremes();
        test_short_word();
        test_long_word();
        test_mid_frame_start();
        test_reset_mid_frame();
        test_back_to_back();
        repeat (20) @(negedge clk);
        check_int("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
